// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - snooping MSI bus controller sharing one RAM port between two cores
//
// Ports:
//   CLK, nRST          clock; asynchronous active-low reset
//   iREN, iaddr        per-core icache read request and address
//   iwait, iload       per-core icache stall (low one cycle = iload valid) and read data
//   dREN, dWEN         per-core dcache read / write request
//   daddr, dstore      per-core dcache word address and store data
//   cctrans, ccwrite   per-core coherence transaction start / requester intends M
//   dwait, dload       per-core dcache stall (low one cycle = word done) and read data
//   ccwait, ccinv      per-core snoop in progress / invalidate snooped block
//   ccsnoopaddr        per-core snooped address
//   ramREN, ramWEN     RAM read / write strobes
//   ramaddr, ramstore  RAM address and write data
//   ramload, ram_wait  RAM read data; RAM busy (low = access completes this cycle)

module coherence_bus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CPUS   = 2    // only 2 is legal: core indices below are 1 bit wide
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [CPUS-1:0]               iREN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   iaddr,
    output logic [CPUS-1:0]               iwait,
    output logic [CPUS-1:0][DATA_W-1:0]   iload,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  logic [CPUS-1:0][ADDR_W-1:0]   daddr,
    input  logic [CPUS-1:0][DATA_W-1:0]   dstore,
    input  logic [CPUS-1:0]               cctrans,
    input  logic [CPUS-1:0]               ccwrite,
    output logic [CPUS-1:0]               dwait,
    output logic [CPUS-1:0][DATA_W-1:0]   dload,
    output logic [CPUS-1:0]               ccwait,
    output logic [CPUS-1:0]               ccinv,
    output logic [CPUS-1:0][ADDR_W-1:0]   ccsnoopaddr,
    output logic                          ramREN,
    output logic                          ramWEN,
    output logic [ADDR_W-1:0]             ramaddr,
    output logic [DATA_W-1:0]             ramstore,
    input  logic [DATA_W-1:0]             ramload,
    input  logic                          ram_wait
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] SNOOP  = 4'd1;
    localparam logic [3:0] SNRESP = 4'd2;
    localparam logic [3:0] FWD0   = 4'd3;
    localparam logic [3:0] FWD1   = 4'd4;
    localparam logic [3:0] RAM0   = 4'd5;
    localparam logic [3:0] RAM1   = 4'd6;
    localparam logic [3:0] WB0    = 4'd7;
    localparam logic [3:0] WB1    = 4'd8;
    localparam logic [3:0] INVS   = 4'd9;
    localparam logic [3:0] IFETCH = 4'd10;

    logic [3:0]        state;
    logic [3:0]        next_state;
    logic              req;          // granted core (dcache or icache, by transaction class)
    logic              other;        // the snooped core
    logic [ADDR_W-1:0] addr;
    logic              ccw;
    logic              last_grant;
    logic              last_igrant;
    logic [CPUS-1:0]   dreq;
    logic              dgnt;
    logic              ignt;

    assign other = ~req;
    assign dreq  = dREN | dWEN | cctrans;

    // Round-robin: prefer the core that did not win last time, else whoever asks.
    assign dgnt = dreq[~last_grant] ? ~last_grant : last_grant;
    assign ignt = iREN[~last_igrant] ? ~last_igrant : last_igrant;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            req         <= 1'b0;
            addr        <= '0;
            ccw         <= 1'b0;
            last_grant  <= 1'b1;
            last_igrant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (|dreq) begin
                    req        <= dgnt;
                    addr       <= daddr[dgnt];
                    ccw        <= ccwrite[dgnt];
                    last_grant <= dgnt;
                end else if (|iREN) begin
                    req         <= ignt;
                    last_igrant <= ignt;
                end
            end
        end
    end

    always_comb begin
        next_state  = state;
        iwait       = '1;
        iload       = '0;
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                // Data-side requests always beat instruction fetches.
                if (|dreq) begin
                    if (dWEN[dgnt])
                        next_state = WB0;
                    else if (dREN[dgnt])
                        next_state = SNOOP;
                    else
                        next_state = INVS;
                end else if (|iREN) begin
                    next_state = IFETCH;
                end
            end
            SNOOP, SNRESP: begin
                ccwait[other]      = 1'b1;
                ccinv[other]       = ccw;
                ccsnoopaddr[other] = addr;
                if (state == SNOOP)
                    next_state = SNRESP;
                else
                    // The snooper raises cctrans only when it owns the block in M.
                    next_state = cctrans[other] ? FWD0 : RAM0;
            end
            FWD0, FWD1: begin
                // Owner's data goes to the requester and to RAM at once, leaving both in S.
                ccwait[other] = 1'b1;
                ramWEN        = 1'b1;
                ramaddr       = daddr[other];
                ramstore      = dstore[other];
                dload[req]    = dstore[other];
                dwait[req]    = ram_wait;
                dwait[other]  = ram_wait;
                if (!ram_wait)
                    next_state = (state == FWD0) ? FWD1 : IDLE;
            end
            RAM0, RAM1: begin
                ramREN     = 1'b1;
                ramaddr    = daddr[req];
                dload[req] = ramload;
                dwait[req] = ram_wait;
                if (!ram_wait)
                    next_state = (state == RAM0) ? RAM1 : IDLE;
            end
            WB0, WB1: begin
                ramWEN     = 1'b1;
                ramaddr    = daddr[req];
                ramstore   = dstore[req];
                dwait[req] = ram_wait;
                if (!ram_wait)
                    next_state = (state == WB0) ? WB1 : IDLE;
            end
            INVS: begin
                ccwait[other]      = 1'b1;
                ccinv[other]       = 1'b1;
                ccsnoopaddr[other] = addr;
                dwait[req]         = 1'b0;
                next_state         = IDLE;
            end
            IFETCH: begin
                ramREN     = 1'b1;
                ramaddr    = iaddr[req];
                iload[req] = ramload;
                iwait[req] = ram_wait;
                if (!ram_wait)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Snooping MSI bus controller for a dual-core system. Shares one unified RAM port between two dcaches and two icaches.
- Sequences cache-to-cache forwarding, invalidation and write-back transactions. Drives each dcache's ccwait/ccinv/ccsnoopaddr.
- Sits between the per-core caches and the RAM model, in place of the single-core memory controller.

Parameters:
ADDR_W, 32, address width (word_t)
DATA_W, 32, data width
CPUS, 2, number of cores; fixed at 2; other values illegal

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
iREN  in  [CPUS]  icache read request
iaddr  in  [CPUS]xADDR_W  icache address
iwait  out  [CPUS]  icache stall; low for one cycle = iload valid
iload  out  [CPUS]xDATA_W  icache read data
dREN, dWEN  in  [CPUS]  dcache read/write request
daddr, dstore  in  [CPUS]xADDR_W/DATA_W  dcache address, store data
cctrans  in  [CPUS]  start of coherence transaction (first word)
ccwrite  in  [CPUS]  requester intends M (invalidate others)
dwait  out  [CPUS]  dcache stall; low one cycle = word accepted/dload valid
dload  out  [CPUS]xDATA_W  dcache read data
ccwait  out  [CPUS]  snoop in progress on this cache
ccinv  out  [CPUS]  invalidate snooped block
ccsnoopaddr  out  [CPUS]xADDR_W  snooped address
ramREN, ramWEN  out  1  RAM read/write strobe
ramaddr, ramstore  out  ADDR_W/DATA_W  RAM address, write data
ramload  in  DATA_W  RAM read data
ram_wait  in  1  high while RAM busy; low = access completes this cycle

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1 (core 0 wins first).
  - All ram strobes, ccwait and ccinv are 0. iwait=dwait='1. Data and address outputs are 0.
- Defaults in every state: iwait=dwait='1, ccwait=ccinv=0, ramREN=ramWEN=0. Unlisted outputs hold 0.
- Arbitration in IDLE:
  - D-requests (dREN|dWEN|cctrans) beat I-requests.
  - Among cores: round-robin. Grant goes to the core != last_grant if it requests; else the other core.
  - Latch req (1 bit), addr and ccwrite at grant. Update last_grant.
  - IDLE→transaction takes 1 cycle; no output responds in the IDLE cycle.
- Transaction classes, latched at grant:
  - WB: dWEN & cctrans. No snoop. WB0→WB1.
  - LD: dREN & cctrans. SNOOP→SNRESP→(FWD0→FWD1 | RAM0→RAM1).
  - INV: cctrans & ~dREN & ~dWEN. Goes to INVS.
  - IFETCH: iREN only. Goes to IF.
- SNOOP (1 cycle): ccwait[o]=1, ccsnoopaddr[o]=latched addr, ccinv[o]=latched ccwrite (o = other core).
- SNRESP: hold the SNOOP outputs. If cctrans[o]=1 (snooper is M), go to FWD0; else go to RAM0.
- FWD0/FWD1 (word 0 then word 1, addr[2]=0/1):
  - Hold ccwait[o]. ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o].
  - dload[req]=dstore[o].
  - When ram_wait=0: dwait[req]=0 and dwait[o]=0 in the same cycle, then advance. FWD1 exit goes to IDLE.
  - Memory is updated on every forward (M→S for both).
- RAM0/RAM1:
  - ramREN=1, ramaddr=daddr[req], dload[req]=ramload.
  - dwait[req]=ram_wait. Advance on ram_wait=0. RAM1 exit goes to IDLE.
  - ccwait/ccinv are not asserted.
- WB0/WB1: ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req]. dwait[req]=ram_wait.
- INVS (1 cycle): ccwait[o]=1, ccinv[o]=1, ccsnoopaddr[o]=addr, dwait[req]=0. Next state IDLE.
- IF: ramREN=1, ramaddr=iaddr[i], iload[i]=ramload, iwait[i]=ram_wait. Exit to IDLE on ram_wait=0. The grant is round-robin, with a separate last_igrant.
- Snoop address to the requester itself is never asserted; ccwait[req]=0 always.
- Requests drop mid-transaction (cache flushed/reset): the transaction still runs to completion; data is ignored. No abort.
- Both cores issuing LD to the same block simultaneously: serialized by round-robin. The second snoops the first's now-S copy, so it takes the RAM0 path.
- Asynchronous reset mid-transaction: immediate return to reset values. RAM strobes drop in the same cycle.
- No combinational path from ram_wait to state; dwait/iwait may depend combinationally on ram_wait.

Test Plan:
- Core0 LD 0x100, core1 block invalid, ram_wait low after 2 cycles → SNOOP, SNRESP, RAM0, RAM1. dload[0] is RAM[0x100] then RAM[0x104]. ccwait[1] is high exactly 2 cycles.
- Core1 holds 0x200 in M with data 0xAAAA/0xBBBB; core0 LD with ccwrite=1 → ccinv[1]=1. FWD0/FWD1 give dload[0]=0xAAAA, 0xBBBB. RAM[0x200]=0xAAAA and RAM[0x204]=0xBBBB are written.
- Core0 INV on 0x300 → one cycle with ccwait[1]=ccinv[1]=1, ccsnoopaddr[1]=0x300, and dwait[0]=0 in the same cycle.
- Both cores issue dREN+cctrans and iREN continuously → grants alternate 0,1,0,1. Icache is served only when neither dcache requests.
- WB from core1 of 0x400 with data 0x1/0x2 → RAM written with no ccwait on core0. dwait[1] falls twice.
- nRST asserted in FWD1 → all strobes 0 immediately and state IDLE. The next request after reset is granted to core0.
